// File: rtl/manchester_decoder_n.sv
// Manchester decoder ("01"=1, "10"=0) with lock tracking, MSB-first word assembly and an
// AXI-Stream output FIFO. WORD_W is expected to be >= (MAX_IN+1)/2 so at most one word completes per cycle.
module manchester_decoder_n #(
    parameter int MAX_IN     = 4,
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int LOCK_CNT   = 4
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [MAX_IN-1:0]           in_bits,
    input  logic [$clog2(MAX_IN+1)-1:0] in_num,
    input  logic                        in_valid,
    output logic [WORD_W-1:0]           m_tdata,
    output logic                        m_tvalid,
    input  logic                        m_tready,
    output logic                        locked,
    output logic                        sync_lost,
    output logic [15:0]                 err_count,
    output logic                        overflow
);
    localparam int NUM_W  = $clog2(MAX_IN + 1);
    localparam int SEQ_N  = MAX_IN + 1;
    localparam int BCNT_W = $clog2(WORD_W + 1);
    localparam int LCNT_W = $clog2(LOCK_CNT + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                carry_q, carry_d;
    logic                carry_flag_q, carry_flag_d;
    logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [15:0]         err_q, err_d;
    logic                sync_lost_q, sync_lost_d;
    logic                overflow_q, overflow_d;
    logic                locked_q;

    logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                tvalid_q;
    logic [WORD_W-1:0]   tdata_q, head_d;

    logic [NUM_W-1:0]    num_s;
    logic                active_s;
    logic [MAX_IN-1:0]   aligned_s;
    logic [SEQ_N-1:0]    seq_s;
    int                  seq_len_s;
    logic [SEQ_N-1:0]    work_s;
    int                  rem_s;
    logic                dead_s;
    logic                bit_s;
    logic                push_s;
    logic [WORD_W-1:0]   push_word_s;
    logic                pop_s;
    logic                full_s;
    logic                push_ok_s;
    logic [CNT_W-1:0]    left_s;

    // Working sequence with the oldest sample in the MSB; the carried half-bit leads when present
    always_comb begin
        num_s     = (in_num > NUM_W'(MAX_IN)) ? NUM_W'(MAX_IN) : in_num;
        active_s  = in_valid && (num_s != {NUM_W{1'b0}});
        aligned_s = in_bits << (NUM_W'(MAX_IN) - num_s);
        if (carry_flag_q) begin
            seq_s     = {carry_q, aligned_s};
            seq_len_s = int'(num_s) + 1;
        end else begin
            seq_s     = {aligned_s, 1'b0};
            seq_len_s = int'(num_s);
        end
    end

    // Pair scan: decode, slip handling, lock tracking and word assembly
    always_comb begin
        state_d      = state_q;
        carry_d      = carry_q;
        carry_flag_d = carry_flag_q;
        lcnt_d       = lcnt_q;
        word_d       = word_q;
        bcnt_d       = bcnt_q;
        err_d        = err_q;
        sync_lost_d  = 1'b0;
        push_s       = 1'b0;
        push_word_s  = {WORD_W{1'b0}};
        dead_s       = 1'b0;
        bit_s        = 1'b0;
        work_s       = seq_s;
        rem_s        = seq_len_s;
        if (active_s) begin
            carry_flag_d = 1'b0;
            carry_d      = 1'b0;
            for (int k = 0; k < SEQ_N; k++) begin
                if (rem_s >= 2) begin
                    if (work_s[SEQ_N-1] != work_s[SEQ_N-2]) begin
                        bit_s = work_s[SEQ_N-2];
                        if (dead_s) begin
                            bit_s = 1'b0;
                        end else if (state_d == ST_LOCKED) begin
                            word_d = {word_d[WORD_W-2:0], bit_s};
                            bcnt_d = bcnt_d + BCNT_W'(1);
                            if (bcnt_d == BCNT_W'(WORD_W)) begin
                                push_s      = 1'b1;
                                push_word_s = word_d;
                                bcnt_d      = {BCNT_W{1'b0}};
                            end else begin
                                push_s = push_s;
                            end
                        end else if (lcnt_d == LCNT_W'(LOCK_CNT - 1)) begin
                            state_d = ST_LOCKED;
                            lcnt_d  = {LCNT_W{1'b0}};
                            word_d  = {WORD_W{1'b0}};
                            bcnt_d  = {BCNT_W{1'b0}};
                        end else begin
                            lcnt_d = lcnt_d + LCNT_W'(1);
                        end
                        work_s = work_s << 2'd2;
                        rem_s  = rem_s - 2;
                    end else begin
                        // Once sync is lost, the rest of the cycle only keeps sample alignment
                        if (dead_s) begin
                            dead_s = 1'b1;
                        end else if (state_d == ST_LOCKED) begin
                            state_d     = ST_HUNT;
                            dead_s      = 1'b1;
                            sync_lost_d = 1'b1;
                            word_d      = {WORD_W{1'b0}};
                            bcnt_d      = {BCNT_W{1'b0}};
                            lcnt_d      = {LCNT_W{1'b0}};
                            if (err_d != 16'hFFFF) begin
                                err_d = err_d + 16'd1;
                            end else begin
                                err_d = err_d;
                            end
                        end else begin
                            lcnt_d = {LCNT_W{1'b0}};
                        end
                        work_s = work_s << 1'b1;
                        rem_s  = rem_s - 1;
                    end
                end else if (rem_s == 1) begin
                    carry_d      = work_s[SEQ_N-1];
                    carry_flag_d = 1'b1;
                    rem_s        = 0;
                end else begin
                    rem_s = 0;
                end
            end
        end else begin
            dead_s = 1'b0;
        end
    end

    // FIFO pointer/count update and the value presented at the head after this edge
    always_comb begin
        pop_s      = tvalid_q & m_tready;
        full_s     = (count_q == CNT_W'(FIFO_DEPTH));
        push_ok_s  = push_s & (~full_s | pop_s);
        overflow_d = overflow_q | (push_s & ~push_ok_s);
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            left_s   = count_q - CNT_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
            left_s   = count_q;
        end
        if (push_ok_s) begin
            count_d = left_s + CNT_W'(1);
        end else begin
            count_d = left_s;
        end
        if (left_s != {CNT_W{1'b0}}) begin
            head_d = mem_q[rd_ptr_d];
        end else if (push_ok_s) begin
            head_d = push_word_s;
        end else begin
            head_d = tdata_q;
        end
    end

    // Decoder state, FIFO storage and registered outputs
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= ST_HUNT;
            carry_q      <= 1'b0;
            carry_flag_q <= 1'b0;
            lcnt_q       <= {LCNT_W{1'b0}};
            word_q       <= {WORD_W{1'b0}};
            bcnt_q       <= {BCNT_W{1'b0}};
            err_q        <= 16'h0000;
            sync_lost_q  <= 1'b0;
            overflow_q   <= 1'b0;
            locked_q     <= 1'b0;
            mem_q        <= '{default: {WORD_W{1'b0}}};
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            tvalid_q     <= 1'b0;
            tdata_q      <= {WORD_W{1'b0}};
        end else begin
            state_q      <= state_d;
            carry_q      <= carry_d;
            carry_flag_q <= carry_flag_d;
            lcnt_q       <= lcnt_d;
            word_q       <= word_d;
            bcnt_q       <= bcnt_d;
            err_q        <= err_d;
            sync_lost_q  <= sync_lost_d;
            overflow_q   <= overflow_d;
            locked_q     <= (state_d == ST_LOCKED);
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= push_word_s;
            end
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            tvalid_q     <= (count_d != {CNT_W{1'b0}});
            tdata_q      <= head_d;
        end
    end

    assign m_tdata   = tdata_q;
    assign m_tvalid  = tvalid_q;
    assign locked    = locked_q;
    assign sync_lost = sync_lost_q;
    assign err_count = err_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/manchester_decoder_n.md
MANCHESTER_DECODER_N -- requirements
Module: manchester_decoder_n

Interface
REQ-001 SHALL have parameter MAX_IN, default 4, meaning the maximum number of half-bit samples accepted per cycle (range 2..8).
REQ-002 SHALL have parameter WORD_W, default 8, meaning the output word width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the output word FIFO depth (a power of 2).
REQ-004 SHALL have parameter LOCK_CNT, default 4, meaning the number of consecutive slip-free decoded bits required to declare lock.
REQ-005 SHALL have port aclk, input, 1 bit: clock; all logic is on the rising edge.
REQ-006 SHALL have port aresetn, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port in_bits, input, MAX_IN bits: half-bit samples; in_bits[in_num-1] is the oldest sample.
REQ-008 SHALL have port in_num, input, clog2(MAX_IN+1) bits: count of valid samples in in_bits.
REQ-009 SHALL have port in_valid, input, 1 bit: qualifies in_bits and in_num.
REQ-010 SHALL have port m_tdata, output, WORD_W bits: decoded word, first-decoded bit in the MSB.
REQ-011 SHALL have port m_tvalid, output, 1 bit: AXI-Stream valid.
REQ-012 SHALL have port m_tready, input, 1 bit: AXI-Stream ready.
REQ-013 SHALL have port locked, output, 1 bit: decoder is in the LOCKED state.
REQ-014 SHALL have port sync_lost, output, 1 bit: one-cycle pulse on LOCKED->HUNT.
REQ-015 SHALL have port err_count, output, 16 bits: saturating count of slips detected while LOCKED.
REQ-016 SHALL have port overflow, output, 1 bit: sticky flag set when a word is dropped because the FIFO is full.

Function
REQ-017 SHALL form the working sequence each cycle with in_valid=1 and in_num>0 as the carried half-bit (if carry_flag is set, oldest) followed by the in_num new samples in age order.
REQ-018 SHALL clamp in_num>MAX_IN to MAX_IN; in_valid=0 or in_num=0 SHALL leave all state unchanged.
REQ-019 SHALL scan the sequence oldest-first: an unequal pair (a,b) decodes bit b and consumes 2 samples; an equal pair is a slip and consumes 1 sample.
REQ-020 SHALL store exactly 1 leftover sample as the carry (carry_flag=1), and otherwise clear carry_flag; at most one sample is ever carried.
REQ-021 SHALL, in HUNT, count consecutive decoded bits, reset that count on a slip, and enter LOCKED in the cycle the count reaches LOCK_CNT; bits decoded in HUNT SHALL NOT enter words.
REQ-022 SHALL, when LOCKED and a slip occurs, go to HUNT, discard the partial word and any later bits of that cycle, pulse sync_lost, and increment err_count (saturating at 16'hFFFF).
REQ-023 SHALL, when LOCKED, shift decoded bits MSB-first into the word assembler; on reaching WORD_W bits it SHALL push the word to the FIFO and carry the remaining bits of the same cycle into the next word.
REQ-024 SHALL drop a push to a full FIFO and set overflow; a pop (m_tvalid and m_tready) in the same cycle frees the slot, so the push succeeds.
REQ-025 SHALL assert m_tvalid in the cycle after the push when the FIFO was empty; m_tdata SHALL be stable while m_tvalid=1 and m_tready=0.
REQ-026 SHALL have a fixed latency of 1 cycle from the input sample to the state/carry update.

Reset
REQ-027 SHALL, with aresetn=0 at a clock edge, set state=HUNT, carry_flag=0, carry=0, lock count=0, partial word empty, FIFO empty, m_tvalid=0, m_tdata=0, locked=0, sync_lost=0, err_count=0, overflow=0.
REQ-028 SHALL let reset asserted mid-word or mid-handshake discard all data, with no word emitted afterwards.

Verification
REQ-029 SHALL be verified with MAX_IN=4 for lock plus word decode: Manchester stream for 4 preamble 1s then 0xA5 ("01"=1, "10"=0), 4 samples/cycle -> locked rises after the 4th bit; one word m_tdata=8'hA5.
REQ-030 SHALL be verified for odd grouping: the same stream fed as 3,3,1,2,... samples/cycle -> identical output 8'hA5, with carry exercised.
REQ-031 SHALL be verified for a slip: samples "0011" injected mid-word while LOCKED -> sync_lost pulses once, err_count=1, partial word discarded, locked=0.
REQ-032 SHALL be verified for backpressure: m_tready=0 while 5 words arrive -> first 4 held in order, overflow=1, 5th dropped; releasing m_tready drains the 4 words.
REQ-033 SHALL be verified for simultaneous pop and push with a full FIFO -> no overflow, with the word count remaining at 4.
REQ-034 SHALL be verified for reset mid-word: aresetn=0 for 1 cycle after 5 bits -> all outputs at reset values and relock required.
